// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
// Optional build macro IMEM_OOR_NOP_EN: out-of-range fetches return a NOP
// (addi x0,x0,0) instead of zero; rsp_err_o is raised either way.
package imem_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Word returned alongside rsp_err_o for an address beyond DEPTH.
  function automatic logic [INST_W-1:0] oor_inst();
`ifdef IMEM_OOR_NOP_EN
    return INST_NOP;
`else
    return '0;
`endif
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channels plus the program-load port.
// master: fetch unit / loader side; slave: imem_responder.
interface imem_responder_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = 6
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [INST_W-1:0] rsp_inst_o;
  logic              rsp_err_o;
  logic              ld_we_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [INST_W-1:0] ld_data_i;

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    input  req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    output req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port for program
// load, one asynchronous read port sampled by the responder's capture edge.
// Contents are not reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [INST_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_L);

  // Load writes; addresses beyond DEPTH are dropped.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Old contents are seen by a read on the same edge as a write.
  assign rd_data = mem[rd_addr[IDX_W-1:0]];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one word-address fetch at a time,
// waits WAIT_CYC cycles, then presents the instruction until the requester
// takes it. Optional macro IMEM_OOR_NOP_EN selects the out-of-range word
// (see imem_pkg::oor_inst).
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  imem_responder_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rsp_valid_q;
  logic [INST_W-1:0] rsp_inst_q;
  logic              rsp_err_q;

  logic [ADDR_W-1:0] cap_addr;
  logic              cap_in_range;
  logic [INST_W-1:0] rd_data;

  // With no wait states the capture edge is the accept edge, so the address
  // comes straight from the request bus rather than the latch.
  always_comb begin
    cap_addr     = (state == IDLE) ? bus.req_addr_i : addr_q;
    cap_in_range = ({1'b0, cap_addr} < DEPTH_L);
  end

  imem_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk_i),
    .wr_en   (bus.ld_we_i),
    .wr_addr (bus.ld_addr_i),
    .wr_data (bus.ld_data_i),
    .rd_addr (cap_addr),
    .rd_data (rd_data)
  );

  // Ready is decoded from state but forced low while reset is held.
  assign bus.req_ready_o = rst_i && (state == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_inst_o  = rsp_inst_q;
  assign bus.rsp_err_o   = rsp_err_q;

  // Request/wait/response sequencing with registered response outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            addr_q <= bus.req_addr_i;
            if (WAIT_CYC == 0) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= !cap_in_range;
              rsp_inst_q  <= cap_in_range ? rd_data : oor_inst();
            end else begin
              cnt   <= WAIT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !cap_in_range;
            rsp_inst_q  <= cap_in_range ? rd_data : oor_inst();
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: instance A (DEPTH 64, WAIT_CYC 1) and
// instance B (DEPTH 32, WAIT_CYC 0) share clock and reset.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int WC[2]  = '{1, 0};
  localparam int DEP[2] = '{64, 32};
`ifdef IMEM_OOR_NOP_EN
  localparam logic [31:0] OOR = 32'h0000_0013;
`else
  localparam logic [31:0] OOR = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        rv [2];
  logic [5:0]  ra [2];
  logic        rr [2];
  logic        we [2];
  logic [5:0]  la [2];
  logic [31:0] ld [2];
  logic        o_ready [2];
  logic        o_valid [2];
  logic [31:0] o_inst  [2];
  logic        o_err   [2];

  imem_responder_if #(.ADDR_W(6)) ifa ();
  imem_responder_if #(.ADDR_W(6)) ifb ();

  assign ifa.req_valid_i = rv[0];
  assign ifa.req_addr_i  = ra[0];
  assign ifa.rsp_ready_i = rr[0];
  assign ifa.ld_we_i     = we[0];
  assign ifa.ld_addr_i   = la[0];
  assign ifa.ld_data_i   = ld[0];
  assign ifb.req_valid_i = rv[1];
  assign ifb.req_addr_i  = ra[1];
  assign ifb.rsp_ready_i = rr[1];
  assign ifb.ld_we_i     = we[1];
  assign ifb.ld_addr_i   = la[1];
  assign ifb.ld_data_i   = ld[1];
  assign o_ready[0] = ifa.req_ready_o;
  assign o_valid[0] = ifa.rsp_valid_o;
  assign o_inst[0]  = ifa.rsp_inst_o;
  assign o_err[0]   = ifa.rsp_err_o;
  assign o_ready[1] = ifb.req_ready_o;
  assign o_valid[1] = ifb.rsp_valid_o;
  assign o_inst[1]  = ifb.rsp_inst_o;
  assign o_err[1]   = ifb.rsp_err_o;

  imem_responder #(.ADDR_W(6), .DEPTH(64), .WAIT_CYC(1)) dut_a (
    .clk_i (clk), .rst_i (rst_n), .bus (ifa)
  );
  imem_responder #(.ADDR_W(6), .DEPTH(32), .WAIT_CYC(0)) dut_b (
    .clk_i (clk), .rst_i (rst_n), .bus (ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a fetch occupies the responder from its accept
  // edge until the response is taken; the word is what memory held just
  // before the edge WAIT_CYC cycles after acceptance.
  logic        m_busy  [2];
  logic        m_valid [2];
  logic        m_err   [2];
  logic [31:0] m_inst  [2];
  logic [5:0]  m_addr  [2];
  int          m_left  [2];
  logic [31:0] m_mem   [2][64];

  function automatic logic [31:0] model_word(input int i, input logic [5:0] a);
    return (int'(a) < DEP[i]) ? m_mem[i][a] : OOR;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  <= 1'b0;
        m_valid[i] <= 1'b0;
        m_err[i]   <= 1'b0;
        m_inst[i]  <= '0;
        m_addr[i]  <= '0;
        m_left[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (we[i] && int'(la[i]) < DEP[i]) m_mem[i][la[i]] <= ld[i];
        if (!m_busy[i]) begin
          if (rv[i]) begin
            m_busy[i] <= 1'b1;
            m_addr[i] <= ra[i];
            if (WC[i] == 0) begin
              m_valid[i] <= 1'b1;
              m_inst[i]  <= model_word(i, ra[i]);
              m_err[i]   <= (int'(ra[i]) >= DEP[i]);
            end else begin
              m_left[i] <= WC[i];
            end
          end
        end else if (!m_valid[i]) begin
          if (m_left[i] == 1) begin
            m_valid[i] <= 1'b1;
            m_inst[i]  <= model_word(i, m_addr[i]);
            m_err[i]   <= (int'(m_addr[i]) >= DEP[i]);
          end
          m_left[i] <= m_left[i] - 1;
        end else if (rr[i]) begin
          m_valid[i] <= 1'b0;
          m_busy[i]  <= 1'b0;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.ready", i == 0 ? "A" : "B"), 32'(o_ready[i]), 32'(rst_n && !m_busy[i]));
      check($sformatf("%s.valid", i == 0 ? "A" : "B"), 32'(o_valid[i]), 32'(m_valid[i]));
      check($sformatf("%s.inst",  i == 0 ? "A" : "B"), o_inst[i], m_inst[i]);
      check($sformatf("%s.err",   i == 0 ? "A" : "B"), 32'(o_err[i]), 32'(m_err[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rr[i] = 1'b0;
      we[i] = 1'b0; la[i] = '0; ld[i] = '0;
    end
    #1 rst_n = 1'b0;
    tick(); tick();
    check("rst.A.ready", 32'(o_ready[0]), 32'd0);
    check("rst.A.valid", 32'(o_valid[0]), 32'd0);
    check("rst.A.inst",  o_inst[0], 32'd0);
    check("rst.B.err",   32'(o_err[1]), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle.A.ready", 32'(o_ready[0]), 32'd1);

    // Program load: A gets A000_00xx, B gets B000_00xx; B also sees an
    // out-of-range write that must be dropped.
    for (int k = 0; k < 32; k++) begin
      we[0] = 1'b1; la[0] = 6'(k); ld[0] = 32'hA000_0000 + 32'(k);
      we[1] = 1'b1; la[1] = 6'(k); ld[1] = 32'hB000_0000 + 32'(k);
      tick();
    end
    la[0] = 6'd5;  ld[0] = 32'hDEAD_BEEF;
    la[1] = 6'd40; ld[1] = 32'h5555_5555;
    tick();
    we[0] = 1'b0; we[1] = 1'b0;
    tick();

    // Basic fetch, one wait state: valid two cycles after request cycle.
    rv[0] = 1'b1; ra[0] = 6'd5;
    tick();
    rv[0] = 1'b0; ra[0] = 6'd63;
    check("t1.c1.valid", 32'(o_valid[0]), 32'd0);
    check("t1.c1.ready", 32'(o_ready[0]), 32'd0);
    tick();
    check("t1.c2.valid", 32'(o_valid[0]), 32'd1);
    check("t1.c2.inst",  o_inst[0], 32'hDEAD_BEEF);
    check("t1.c2.err",   32'(o_err[0]), 32'd0);
    rr[0] = 1'b1;
    tick();
    rr[0] = 1'b0;
    check("t1.c3.ready", 32'(o_ready[0]), 32'd1);

    // Zero wait states, back-to-back with requester always ready.
    rr[1] = 1'b1; rv[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ra[1] = 6'(k);
      tick();
      check("t2.resp.inst",  o_inst[1], 32'hB000_0000 + 32'(k));
      check("t2.resp.ready", 32'(o_ready[1]), 32'd0);
      ra[1] = 6'd33;
      tick();
      check("t2.idle.valid", 32'(o_valid[1]), 32'd0);
    end
    rv[1] = 1'b0;
    tick();

    // Backpressure on A.
    rv[0] = 1'b1; ra[0] = 6'd7;
    tick();
    rv[0] = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t3.hold.valid", 32'(o_valid[0]), 32'd1);
      check("t3.hold.inst",  o_inst[0], 32'hA000_0007);
      tick();
    end
    rr[0] = 1'b1;
    tick();
    rr[0] = 1'b0;
    check("t3.idle.ready", 32'(o_ready[0]), 32'd1);
    check("t3.idle.valid", 32'(o_valid[0]), 32'd0);

    // Range boundaries on B (DEPTH 32).
    rr[1] = 1'b1; rv[1] = 1'b1; ra[1] = 6'd31;
    tick();
    check("t4.31.inst", o_inst[1], 32'hB000_001F);
    check("t4.31.err",  32'(o_err[1]), 32'd0);
    ra[1] = 6'd32;
    tick(); tick();
    check("t4.32.err",  32'(o_err[1]), 32'd1);
    check("t4.32.inst", o_inst[1], OOR);
    ra[1] = 6'd40;
    tick(); tick();
    check("t4.40.err",  32'(o_err[1]), 32'd1);
    check("t4.40.inst", o_inst[1], OOR);
    rv[1] = 1'b0;
    tick();

    // Write on the capture edge is not seen; a later fetch sees it.
    rr[0] = 1'b0; rv[0] = 1'b1; ra[0] = 6'd9;
    tick();
    rv[0] = 1'b0;
    we[0] = 1'b1; la[0] = 6'd9; ld[0] = 32'h1111_1111;
    tick();
    we[0] = 1'b0;
    check("t5.old.inst", o_inst[0], 32'hA000_0009);
    rr[0] = 1'b1;
    tick();
    rr[0] = 1'b0; rv[0] = 1'b1; ra[0] = 6'd9;
    tick();
    rv[0] = 1'b0;
    tick();
    check("t5.new.inst", o_inst[0], 32'h1111_1111);
    rr[0] = 1'b1;
    tick();

    // Write in the request cycle lands before capture and is seen.
    rv[0] = 1'b1; ra[0] = 6'd10;
    we[0] = 1'b1; la[0] = 6'd10; ld[0] = 32'h2222_2222;
    tick();
    rv[0] = 1'b0; we[0] = 1'b0;
    tick();
    check("t5b.inst", o_inst[0], 32'h2222_2222);
    tick();

    // Reset during the wait state aborts the fetch.
    rr[0] = 1'b0; rv[0] = 1'b1; ra[0] = 6'd3;
    tick();
    rv[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst.ready", 32'(o_ready[0]), 32'd0);
    check("t6.rst.valid", 32'(o_valid[0]), 32'd0);
    check("t6.rst.inst",  o_inst[0], 32'd0);
    check("t6.rst.err",   32'(o_err[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    rr[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6.stray.valid", 32'(o_valid[0]), 32'd0);
    end
    rv[0] = 1'b1; ra[0] = 6'd4;
    tick();
    rv[0] = 1'b0; rr[0] = 1'b0;
    tick();
    check("t6.new.valid", 32'(o_valid[0]), 32'd1);
    check("t6.new.inst",  o_inst[0], 32'hA000_0004);
    rr[0] = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
